// File: rtl/divisor_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake. Divide-by-zero finishes in one cycle with Q = all ones, R = A.
module divisor_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CountLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH+1:0] SumOne = (WIDTH + 2)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] bq_q, bq_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   ps;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   trial;
    logic             nb;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] qsh_next;
    logic             last_calc;
    logic             b_is_zero;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            qsh_q   <= '0;
            bq_q    <= '0;
            count_q <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            p_q     <= p_d;
            qsh_q   <= qsh_d;
            bq_q    <= bq_d;
            count_q <= count_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // ---------------------------------------------------------------- shift-and-subtract step
    // Subtract as add of inverted divisor with carry-in 1; carry-out set means no borrow.
    always_comb begin
        ps        = {p_q[WIDTH-1:0], qsh_q[WIDTH-1]};
        sum       = {1'b0, ps} + {1'b0, ~{1'b0, bq_q}} + SumOne;
        trial     = sum[WIDTH:0];
        nb        = sum[WIDTH+1];
        p_next    = nb ? trial : ps;
        qsh_next  = {qsh_q[WIDTH-2:0], nb};
        last_calc = (count_q == CountLast);
        b_is_zero = (B == '0);
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = b_is_zero ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (last_calc) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        p_d     = p_q;
        qsh_d   = qsh_q;
        bq_d    = bq_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (b_is_zero) begin
                        q_d  = '1;
                        r_d  = A;
                        dz_d = 1'b1;
                    end else begin
                        p_d     = '0;
                        qsh_d   = A;
                        bq_d    = B;
                        count_d = '0;
                        dz_d    = 1'b0;
                    end
                end
            end
            StCalc: begin
                p_d     = p_next;
                qsh_d   = qsh_next;
                count_d = count_q + 1'b1;
                // Publish results straight from the final step's next values.
                if (last_calc) begin
                    q_d = qsh_next;
                    r_d = p_next[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        Q        = q_q;
        R        = r_q;
        div_zero = dz_q;
    end

endmodule
